irq_priority_ctrl: RTL

IRQ_PRIORITY_CTRL -- requirements
Module: irq_priority_ctrl

---
 rtl/irq_priority_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/irq_priority_ctrl.sv
// Interrupt priority controller: synchronises four level request lines,
// latches rising edges as sticky pending bits, flags edges lost to an
// already-pending line, and presents the highest-priority unmasked request
// through a two-state valid/ack handshake.
module irq_priority_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] irq,
    input  logic [3:0] mask,
    input  logic       ack,
    output logic [1:0] out,
    output logic       valid,
    output logic [3:0] pending,
    output logic [3:0] lost
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic [3:0] dly_q,   dly_d;
    logic [3:0] pending_q, pending_d;
    logic [3:0] lost_q,    lost_d;
    state_t     state_q,   state_d;
    logic [1:0] out_q,     out_d;
    logic       valid_q,   valid_d;

    logic [3:0] rise;
    logic [3:0] clr;
    logic [3:0] eligible;
    logic [1:0] enc;

    // Synchroniser chain plus delay stage used for rise detection
    always_comb begin
        sync1_d = irq;
        sync2_d = sync1_q;
        dly_d   = sync2_q;
        rise    = sync2_q & ~dly_q;
    end

    // Pending/lost update: an incoming rise beats a same-cycle ack-clear
    always_comb begin
        clr = '0;
        if (state_q == PRESENT && ack) begin
            clr[out_q] = 1'b1;
        end
        pending_d = (pending_q & ~clr) | rise;
        lost_d    = lost_q | (rise & pending_q & ~clr);
    end

    // Fixed-priority encoder over unmasked pending lines, bit 3 highest
    always_comb begin
        eligible = pending_q & ~mask;
        if (eligible[3]) begin
            enc = 2'b11;
        end else if (eligible[2]) begin
            enc = 2'b10;
        end else if (eligible[1]) begin
            enc = 2'b01;
        end else begin
            enc = 2'b00;
        end
    end

    // Next-state logic: out is frozen while presenting, held while idle
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (eligible != 4'b0000) begin
                    state_d = PRESENT;
                    out_d   = enc;
                    valid_d = 1'b1;
                end
            end
            PRESENT: begin
                if (ack) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Input synchroniser and request bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            dly_q     <= '0;
            pending_q <= '0;
            lost_q    <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            dly_q     <= dly_d;
            pending_q <= pending_d;
            lost_q    <= lost_d;
        end
    end

    // Presentation FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= 2'b00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out     = out_q;
    assign valid   = valid_q;
    assign pending = pending_q;
    assign lost    = lost_q;

endmodule
